// File: rtl/cmp_pkg.sv
// Shared mode codes, state encoding and result helper for the chunked comparator.
package cmp_pkg;

    localparam logic [1:0] CMP_EQ  = 2'b00;
    localparam logic [1:0] CMP_NE  = 2'b01;
    localparam logic [1:0] CMP_LT  = 2'b10;
    localparam logic [1:0] CMP_LTU = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Map a resolved (eq, lt) pair onto the requested comparison.
    function automatic logic cmp_result(input logic [1:0] mode, input logic eq, input logic lt);
        case (mode)
            CMP_EQ:  cmp_result = eq;
            CMP_NE:  cmp_result = ~eq;
            default: cmp_result = lt;
        endcase
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational W-bit chunk comparator; signed ordering only when is_signed is set.
module chunk_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_signed,
    output logic         eq,
    output logic         lt
);

    always_comb begin
        eq = (a == b);
        if (is_signed)
            lt = ($signed(a) < $signed(b));
        else
            lt = (a < b);
    end

endmodule

// File: rtl/chunked_compare.sv
// Multi-cycle EQ/NE/LT/LTU comparator scanning W bits per cycle, MSB chunk first.
// Build option CMP_EARLY_EXIT_EN: leave SCAN at the first mismatching chunk.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  ST_IDLE | waiting for operands, in_ready high
//  ST_SCAN | comparing chunk idx of the captured operands, one per cycle
//  ST_HOLD | Z valid, waiting for out_ready
module chunked_compare
    import cmp_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic [1:0]   mode,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         Z
);

    localparam int NC = N / W;
    localparam int IW = (NC > 1) ? $clog2(NC) : 1;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [N-1:0]  xr;
    logic [N-1:0]  yr;
    logic [1:0]    mr;

    logic [W-1:0]  xc;
    logic [W-1:0]  yc;
    logic          top_signed;
    logic          ceq;
    logic          clt;

`ifndef CMP_EARLY_EXIT_EN
    logic          found;
    logic          lt_l;
`endif

    always_comb begin
        xc = '0;
        yc = '0;
        for (int i = 0; i < NC; i++) begin
            if (idx == IW'(i)) begin
                xc = xr[i*W +: W];
                yc = yr[i*W +: W];
            end
        end
    end

    // Only the sign-bearing top chunk is compared signed, and only for LT.
    assign top_signed = (mr == CMP_LT) && (idx == IW'(NC - 1));

    chunk_cmp #(.W(W)) u_chunk_cmp (
        .a         (xc),
        .b         (yc),
        .is_signed (top_signed),
        .eq        (ceq),
        .lt        (clt)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_HOLD);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= ST_IDLE;
            idx   <= IW'(NC - 1);
            xr    <= '0;
            yr    <= '0;
            mr    <= '0;
            Z     <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
            found <= 1'b0;
            lt_l  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && !abort) begin
                        xr    <= X;
                        yr    <= Y;
                        mr    <= mode;
                        idx   <= IW'(NC - 1);
                        state <= ST_SCAN;
`ifndef CMP_EARLY_EXIT_EN
                        found <= 1'b0;
                        lt_l  <= 1'b0;
`endif
                    end
                end
                ST_SCAN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
`ifdef CMP_EARLY_EXIT_EN
                        if (!ceq) begin
                            Z     <= cmp_result(mr, 1'b0, clt);
                            state <= ST_HOLD;
                        end else if (idx == '0) begin
                            Z     <= cmp_result(mr, 1'b1, 1'b0);
                            state <= ST_HOLD;
                        end else begin
                            idx <= idx - IW'(1);
                        end
`else
                        // First mismatch is frozen; later chunks cannot change the outcome.
                        if (idx == '0) begin
                            if (found)
                                Z <= cmp_result(mr, 1'b0, lt_l);
                            else if (!ceq)
                                Z <= cmp_result(mr, 1'b0, clt);
                            else
                                Z <= cmp_result(mr, 1'b1, 1'b0);
                            state <= ST_HOLD;
                        end else begin
                            if (!found && !ceq) begin
                                found <= 1'b1;
                                lt_l  <= clt;
                            end
                            idx <= idx - IW'(1);
                        end
`endif
                    end
                end
                ST_HOLD: begin
                    if (abort || out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
